// File: rtl/midi_voice_allocator_if.sv
// Decoder-to-allocator bus: decoded MIDI events in, packed per-voice state out.
interface midi_voice_allocator_if #(
  parameter int pChannel = 4
);
  logic [6:0]            iNoteNumber;
  logic [6:0]            iVelocity;
  logic                  iNoteOn;
  logic                  iNoteOff;
  logic                  iSustain;
  logic                  iAllNotesOff;
  logic [pChannel*7-1:0] oNoteNumber;
  logic [pChannel*7-1:0] oVelocity;
  logic [pChannel-1:0]   oNoteOn;
  logic [pChannel-1:0]   oNoteStart;
  logic                  oSteal;
  logic                  oDrop;

  modport master (
    output iNoteNumber, iVelocity, iNoteOn, iNoteOff, iSustain, iAllNotesOff,
    input  oNoteNumber, oVelocity, oNoteOn, oNoteStart, oSteal, oDrop
  );

  modport slave (
    input  iNoteNumber, iVelocity, iNoteOn, iNoteOff, iSustain, iAllNotesOff,
    output oNoteNumber, oVelocity, oNoteOn, oNoteStart, oSteal, oDrop
  );
endinterface

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: retrigger / free-voice / oldest-steal assignment with age ranks.
// Optional sustain-pedal hold logic is enabled by defining MIDI_SUSTAIN_EN.
module midi_voice_allocator #(
  parameter int pChannel   = 4,
  parameter     pStealMode = "oldest",
  parameter     pSim       = "no"
) (
  input logic                    iCLK,
  input logic                    iRST,
  midi_voice_allocator_if.slave  bus
);

  localparam int cIdxW        = $clog2(pChannel);
  localparam bit cStealOldest = (pStealMode == "oldest");
  localparam bit unusedSimFlag = (pSim == "yes");

  typedef logic [cIdxW-1:0] rank_t;

  logic [6:0]          noteReg [pChannel];
  logic [6:0]          noteNext[pChannel];
  logic [6:0]          velReg  [pChannel];
  logic [6:0]          velNext [pChannel];
  rank_t               rankReg [pChannel];
  rank_t               rankNext[pChannel];
  logic [pChannel-1:0] gateReg, gateNext;
  logic [pChannel-1:0] startReg, startNext;
  logic                stealReg, stealNext;
  logic                dropReg, dropNext;
`ifdef MIDI_SUSTAIN_EN
  logic [pChannel-1:0] holdReg, holdNext;
  logic                sustainPrev;
`else
  logic                unusedSustain;
  assign unusedSustain = bus.iSustain;
`endif

  logic  noteOnEff, noteOffEff;
  logic  matchFound, freeFound, selValid;
  rank_t matchIdx, freeIdx, oldestIdx, selIdx, selRank;

  assign noteOnEff  = bus.iNoteOn && (bus.iVelocity != 7'd0);
  assign noteOffEff = bus.iNoteOff || (bus.iNoteOn && (bus.iVelocity == 7'd0));

  // Descending scan so the lowest index wins each search.
  always_comb begin
    matchFound = 1'b0;
    matchIdx   = '0;
    freeFound  = 1'b0;
    freeIdx    = '0;
    oldestIdx  = '0;
    for (int x = pChannel - 1; x >= 0; x--) begin
      if (gateReg[x] && (noteReg[x] == bus.iNoteNumber)) begin
        matchFound = 1'b1;
        matchIdx   = rank_t'(x);
      end
      if (!gateReg[x]) begin
        freeFound = 1'b1;
        freeIdx   = rank_t'(x);
      end
      if (rankReg[x] == '0) oldestIdx = rank_t'(x);
    end
  end

  always_comb begin
    gateNext  = gateReg;
    startNext = '0;
    stealNext = 1'b0;
    dropNext  = 1'b0;
    selValid  = 1'b0;
    selIdx    = '0;
    selRank   = '0;
    for (int x = 0; x < pChannel; x++) begin
      noteNext[x] = noteReg[x];
      velNext[x]  = velReg[x];
      rankNext[x] = rankReg[x];
    end
`ifdef MIDI_SUSTAIN_EN
    holdNext = holdReg;
`endif

    if (bus.iAllNotesOff) begin
      gateNext = '0;
`ifdef MIDI_SUSTAIN_EN
      holdNext = '0;
`endif
    end else begin
`ifdef MIDI_SUSTAIN_EN
      if (sustainPrev && !bus.iSustain) begin
        gateNext = gateNext & ~holdReg;
        holdNext = '0;
      end
`endif
      if (noteOnEff) begin
        if (matchFound) begin
          selValid = 1'b1;
          selIdx   = matchIdx;
        end else if (freeFound) begin
          selValid = 1'b1;
          selIdx   = freeIdx;
        end else if (cStealOldest) begin
          selValid  = 1'b1;
          selIdx    = oldestIdx;
          stealNext = 1'b1;
        end else begin
          dropNext = 1'b1;
        end

        for (int x = 0; x < pChannel; x++)
          if (rank_t'(x) == selIdx) selRank = rankReg[x];

        // Winner moves to the youngest rank; younger voices close the gap it leaves.
        if (selValid) begin
          for (int x = 0; x < pChannel; x++) begin
            if (rank_t'(x) == selIdx) begin
              noteNext[x]  = bus.iNoteNumber;
              velNext[x]   = bus.iVelocity;
              gateNext[x]  = 1'b1;
              startNext[x] = 1'b1;
              rankNext[x]  = rank_t'(pChannel - 1);
`ifdef MIDI_SUSTAIN_EN
              holdNext[x]  = 1'b0;
`endif
            end else if (rankReg[x] > selRank) begin
              rankNext[x] = rankReg[x] - rank_t'(1);
            end
          end
        end
      end else if (noteOffEff) begin
        for (int x = 0; x < pChannel; x++) begin
          if (gateReg[x] && (noteReg[x] == bus.iNoteNumber)) begin
`ifdef MIDI_SUSTAIN_EN
            if (bus.iSustain) begin
              holdNext[x] = 1'b1;
            end else begin
              gateNext[x] = 1'b0;
              holdNext[x] = 1'b0;
            end
`else
            gateNext[x] = 1'b0;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      gateReg  <= '0;
      startReg <= '0;
      stealReg <= 1'b0;
      dropReg  <= 1'b0;
      for (int x = 0; x < pChannel; x++) begin
        noteReg[x] <= '0;
        velReg[x]  <= '0;
        rankReg[x] <= rank_t'(x);
      end
`ifdef MIDI_SUSTAIN_EN
      holdReg     <= '0;
      sustainPrev <= 1'b0;
`endif
    end else begin
      gateReg  <= gateNext;
      startReg <= startNext;
      stealReg <= stealNext;
      dropReg  <= dropNext;
      for (int x = 0; x < pChannel; x++) begin
        noteReg[x] <= noteNext[x];
        velReg[x]  <= velNext[x];
        rankReg[x] <= rankNext[x];
      end
`ifdef MIDI_SUSTAIN_EN
      holdReg     <= holdNext;
      sustainPrev <= bus.iSustain;
`endif
    end
  end

  for (genvar x = 0; x < pChannel; x++) begin : gPack
    assign bus.oNoteNumber[7*x +: 7] = noteReg[x];
    assign bus.oVelocity[7*x +: 7]   = velReg[x];
  end

  assign bus.oNoteOn    = gateReg;
  assign bus.oNoteStart = startReg;
  assign bus.oSteal     = stealReg;
  assign bus.oDrop      = dropReg;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench: twin allocators ("oldest" and "none" steal modes) driven in lockstep.
module tb_midi_voice_allocator;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  midi_voice_allocator_if #(.pChannel(4)) busA();
  midi_voice_allocator_if #(.pChannel(4)) busB();

  midi_voice_allocator #(.pChannel(4), .pStealMode("oldest"), .pSim("yes")) dutA (
    .iCLK (clk),
    .iRST (rst),
    .bus  (busA.slave)
  );

  midi_voice_allocator #(.pChannel(4), .pStealMode("none"), .pSim("yes")) dutB (
    .iCLK (clk),
    .iRST (rst),
    .bus  (busB.slave)
  );

  // Drive both DUTs for one cycle, then settle just after the capturing edge.
  task automatic applyStimulus(input logic on, input logic off, input logic [6:0] note,
                               input logic [6:0] vel, input logic sus, input logic allOff,
                               input logic rstIn);
    @(negedge clk);
    rst                = rstIn;
    busA.iNoteOn       = on;
    busA.iNoteOff      = off;
    busA.iNoteNumber   = note;
    busA.iVelocity     = vel;
    busA.iSustain      = sus;
    busA.iAllNotesOff  = allOff;
    busB.iNoteOn       = on;
    busB.iNoteOff      = off;
    busB.iNoteNumber   = note;
    busB.iVelocity     = vel;
    busB.iSustain      = sus;
    busB.iAllNotesOff  = allOff;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    busA.iNoteOn = 0; busA.iNoteOff = 0; busA.iNoteNumber = 0;
    busA.iVelocity = 0; busA.iSustain = 0; busA.iAllNotesOff = 0;
    busB.iNoteOn = 0; busB.iNoteOff = 0; busB.iNoteNumber = 0;
    busB.iVelocity = 0; busB.iSustain = 0; busB.iAllNotesOff = 0;

    applyStimulus(0, 0, 7'd0, 7'd0, 0, 0, 1);
    checkOutput("resetGate",  busA.oNoteOn, 4'b0000);
    checkOutput("resetNote",  busA.oNoteNumber, 28'd0);
    checkOutput("resetVel",   busA.oVelocity, 28'd0);
    checkOutput("resetStart", busA.oNoteStart, 4'b0000);
    checkOutput("resetSteal", busA.oSteal, 1'b0);
    checkOutput("resetDropB", busB.oDrop, 1'b0);
    applyStimulus(0, 0, 7'd0, 7'd0, 0, 0, 0);

    applyStimulus(1, 0, 7'd60, 7'd100, 0, 0, 0);
    checkOutput("alloc60Start", busA.oNoteStart, 4'b0001);
    checkOutput("alloc60Gate",  busA.oNoteOn, 4'b0001);
    checkOutput("alloc60Vel",   busA.oVelocity[6:0], 7'd100);
    applyStimulus(1, 0, 7'd64, 7'd90, 0, 0, 0);
    checkOutput("alloc64Start", busA.oNoteStart, 4'b0010);
    applyStimulus(1, 0, 7'd67, 7'd80, 0, 0, 0);
    checkOutput("alloc67Start", busA.oNoteStart, 4'b0100);
    checkOutput("alloc67Gate",  busA.oNoteOn, 4'b0111);
    checkOutput("alloc67Notes", busA.oNoteNumber, {7'd0, 7'd67, 7'd64, 7'd60});
    applyStimulus(0, 0, 7'd0, 7'd0, 0, 0, 0);
    checkOutput("startOneCycle", busA.oNoteStart, 4'b0000);

    applyStimulus(1, 0, 7'd60, 7'd50, 0, 0, 0);
    checkOutput("retrigStart", busA.oNoteStart, 4'b0001);
    checkOutput("retrigGate",  busA.oNoteOn, 4'b0111);
    checkOutput("retrigVel",   busA.oVelocity[6:0], 7'd50);

    applyStimulus(1, 0, 7'd62, 7'd70, 0, 0, 0);
    checkOutput("fillStart", busA.oNoteStart, 4'b1000);
    checkOutput("fillGate",  busA.oNoteOn, 4'b1111);

    // Age order is now voice1 oldest (voice0 was refreshed by the retrigger).
    applyStimulus(1, 0, 7'd65, 7'd60, 0, 0, 0);
    checkOutput("stealPulse", busA.oSteal, 1'b1);
    checkOutput("stealStart", busA.oNoteStart, 4'b0010);
    checkOutput("stealNotes", busA.oNoteNumber, {7'd62, 7'd67, 7'd65, 7'd60});
    checkOutput("dropPulseB", busB.oDrop, 1'b1);
    checkOutput("dropNotesB", busB.oNoteNumber, {7'd62, 7'd67, 7'd64, 7'd60});
    checkOutput("dropStartB", busB.oNoteStart, 4'b0000);
    applyStimulus(0, 0, 7'd0, 7'd0, 0, 0, 0);
    checkOutput("stealOneCycle", busA.oSteal, 1'b0);
    checkOutput("dropOneCycleB", busB.oDrop, 1'b0);

    applyStimulus(1, 0, 7'd62, 7'd0, 0, 0, 0);
    checkOutput("vel0OffGate",  busA.oNoteOn, 4'b0111);
    checkOutput("vel0OffNotes", busA.oNoteNumber, {7'd62, 7'd67, 7'd65, 7'd60});

    applyStimulus(0, 1, 7'd70, 7'd0, 0, 0, 0);
    checkOutput("offUnheldGate",  busA.oNoteOn, 4'b0111);
    checkOutput("offUnheldNotes", busA.oNoteNumber, {7'd62, 7'd67, 7'd65, 7'd60});
    checkOutput("offUnheldStart", busA.oNoteStart, 4'b0000);

    applyStimulus(1, 1, 7'd70, 7'd10, 0, 0, 0);
    checkOutput("onWinsGate",  busA.oNoteOn, 4'b1111);
    checkOutput("onWinsStart", busA.oNoteStart, 4'b1000);
    checkOutput("onWinsNote",  busA.oNoteNumber[27:21], 7'd70);

    applyStimulus(0, 1, 7'd60, 7'd0, 1, 0, 0);
`ifdef MIDI_SUSTAIN_EN
    checkOutput("sustainHoldGate", busA.oNoteOn, 4'b1111);
`else
    checkOutput("sustainHoldGate", busA.oNoteOn, 4'b1110);
`endif
    applyStimulus(0, 0, 7'd0, 7'd0, 0, 0, 0);
    checkOutput("sustainFallGate", busA.oNoteOn, 4'b1110);

    applyStimulus(1, 0, 7'd72, 7'd30, 0, 0, 0);
    checkOutput("refillStart", busA.oNoteStart, 4'b0001);
    checkOutput("refillGate",  busA.oNoteOn, 4'b1111);
    applyStimulus(1, 0, 7'd73, 7'd30, 0, 1, 0);
    checkOutput("allOffGate",  busA.oNoteOn, 4'b0000);
    checkOutput("allOffStart", busA.oNoteStart, 4'b0000);
    checkOutput("allOffSteal", busA.oSteal, 1'b0);

    applyStimulus(1, 0, 7'd50, 7'd20, 0, 0, 0);
    checkOutput("preRstGate", busA.oNoteOn, 4'b0001);
    applyStimulus(1, 0, 7'd51, 7'd20, 0, 0, 1);
    checkOutput("midRstGate",  busA.oNoteOn, 4'b0000);
    checkOutput("midRstNote",  busA.oNoteNumber, 28'd0);
    checkOutput("midRstVel",   busA.oVelocity, 28'd0);
    checkOutput("midRstStart", busA.oNoteStart, 4'b0000);

    // Ranks restart at rank[x] = x, so a full fill then steal must hit voice 0.
    applyStimulus(1, 0, 7'd40, 7'd1, 0, 0, 0);
    applyStimulus(1, 0, 7'd41, 7'd1, 0, 0, 0);
    applyStimulus(1, 0, 7'd42, 7'd1, 0, 0, 0);
    applyStimulus(1, 0, 7'd43, 7'd1, 0, 0, 0);
    checkOutput("postRstFill", busA.oNoteOn, 4'b1111);
    applyStimulus(1, 0, 7'd44, 7'd1, 0, 0, 0);
    checkOutput("postRstSteal",      busA.oSteal, 1'b1);
    checkOutput("postRstStealStart", busA.oNoteStart, 4'b0001);
    checkOutput("postRstStealNote",  busA.oNoteNumber[6:0], 7'd44);
    checkOutput("postRstDropB",      busB.oDrop, 1'b1);
    checkOutput("postRstKeepB",      busB.oNoteNumber[6:0], 7'd40);

    applyStimulus(0, 0, 7'd0, 7'd0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
Parametrised polyphonic voice allocator. It sits between the MIDI decoder and the per-voice pitch/amp generators, and replaces the daisy-chained channel pipe. It assigns decoded NoteOn events to a free voice, retriggers a voice already holding the same note, and steals the oldest voice when all voices are busy. It also carries velocity, sustain-pedal handling and an all-notes-off command to each voice.

Parameters:
pChannel, 4, number of voices (2..16)
pStealMode, "oldest", "oldest" steals the least-recently allocated voice when full; "none" drops the new note
pSim, "no", simulation flag; has no functional effect in this block

Ports:
iCLK  input  1  system clock
iRST  input  1  synchronous reset, active-high
iNoteNumber  input  7  decoded note number, 0..127
iVelocity  input  7  decoded velocity, 0..127
iNoteOn  input  1  one-cycle NoteOn strobe
iNoteOff  input  1  one-cycle NoteOff strobe
iSustain  input  1  sustain pedal level, 1 = held
iAllNotesOff  input  1  one-cycle strobe that releases every voice
oNoteNumber  output  pChannel*7  per-voice note number; voice x occupies [7x+6:7x]
oVelocity  output  pChannel*7  per-voice velocity, same packing as oNoteNumber
oNoteOn  output  pChannel  per-voice gate, 1 = sounding
oNoteStart  output  pChannel  one-cycle pulse per voice on (re)trigger, used for envelope restart
oSteal  output  1  one-cycle pulse when a voice is stolen
oDrop  output  1  one-cycle pulse when a NoteOn is discarded

Behaviour:
- Reset: all outputs are 0. Age ranks are reset to rank[x] = x, so voice 0 is the oldest. All sustain-hold flags are cleared.
- Latency: every strobe is registered, and outputs update on the clock edge after the strobe cycle. Each strobe is processed in one cycle, so back-to-back strobes are accepted on every cycle.
- NoteOn with iVelocity = 0 is treated as NoteOff, per the MIDI convention.
- NoteOn allocation priority:
  (1) A gated voice with a matching note: retrigger it, load the new velocity, pulse oNoteStart[x], clear its hold flag.
  (2) Otherwise, the lowest-index voice with oNoteOn = 0: load note and velocity, set the gate, pulse oNoteStart.
  (3) Otherwise, with pStealMode "oldest": take the voice with rank 0, load it, pulse oNoteStart and oSteal. With pStealMode "none": pulse oDrop and change no state.
- Age ranks:
  - The ranks form a permutation of 0..pChannel-1.
  - The allocated or retriggered voice receives rank pChannel-1.
  - Every voice whose rank was greater than the old rank of that voice decrements by 1.
  - A freed voice keeps its rank.
- NoteOff releases every gated voice whose note matches (0 or 1 voice in practice) by clearing its gate. oNoteNumber and oVelocity keep their last values after release so the amp stage can play its release tail.
- NoteOff for a note that is not held: no effect.
- Simultaneous iNoteOn and iNoteOff in the same cycle: NoteOn is processed and NoteOff is ignored.
- iAllNotesOff: clears every gate and hold flag in one cycle, ignores iSustain, and overrides iNoteOn/iNoteOff in the same cycle.
- Reset mid-operation: state returns to reset values on the next edge, with no pulse outputs in that cycle.
- oNoteStart, oSteal and oDrop are never asserted for more than one consecutive cycle per event.

Optional Feature:
MIDI_SUSTAIN_EN. When defined:
- A NoteOff matching a gated voice while iSustain = 1 sets that voice's hold flag and keeps its gate.
- On the cycle after a 1->0 falling edge of iSustain is detected, every held voice is ungated and its hold flag is cleared.
- A held voice counts as busy for allocation.
- A NoteOff arriving in the same cycle as the sustain falling edge is processed as an immediate release.

When not defined: iSustain is ignored, there is no hold-flag storage, and NoteOff always releases immediately. The port remains present.

Test Plan:
1. pChannel=4, NoteOn 60/v100, 64/v90, 67/v80 on consecutive cycles -> voices 0, 1, 2 gate; oNoteNumber = {0, 67, 64, 60}; oNoteStart pulses 0001, 0010, 0100 one cycle after each strobe.
2. Five NoteOns 60, 62, 64, 65, 67 with "oldest" -> the fifth steals voice 0 (note 67) and oSteal pulses once. Repeating with "none" -> oDrop pulses and voice 0 keeps note 60.
3. Note 60 held in voice 0, NoteOn 60/v50 -> voice 0 is retriggered with oVelocity = 50, oNoteStart[0] pulses, and no other voice is allocated.
4. NoteOn 62 with velocity 0 while 62 is gated in voice 1 -> oNoteOn[1] falls next cycle and oNoteNumber[1] stays 62. Separately, NoteOff 70 when 70 is not held -> no output change.
5. With MIDI_SUSTAIN_EN: iSustain=1, NoteOff 60 -> gate stays 1. iSustain falls -> oNoteOn[0] clears the cycle after the edge. Without the macro -> the gate clears on the NoteOff.
6. All voices gated, iAllNotesOff pulsed together with NoteOn 72 -> all gates 0 next cycle, NoteOn is ignored, and no oNoteStart pulse occurs. Assert iRST mid-stream -> all outputs 0 next edge.
